// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register-file slave: FSM encoding, register
// indices and the read-only index check.
`timescale 1ns/1ps
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] IDX_CTRL       = 3'd0;
    localparam logic [2:0] IDX_SCRATCH_LO = 3'd1;
    localparam logic [2:0] IDX_SCRATCH_HI = 3'd5;
    localparam logic [2:0] IDX_XFER_CNT   = 3'd6;
    localparam logic [2:0] IDX_ID         = 3'd7;

    function automatic logic is_ro_idx(input logic [2:0] idx);
        return (idx == IDX_XFER_CNT) || (idx == IDX_ID);
    endfunction

endpackage

// File: rtl/apb_slave_regs.sv
// Register bank of the APB slave: CTRL + SCRATCH storage, write decode,
// transfer counter and the read mux.
`timescale 1ns/1ps
module apb_slave_regs
    import apb_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'hA2B0_0001,
    parameter logic [3:0]  RESET_WAIT = 4'd0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_idx,
    input  logic [31:0] i_wr_data,
    input  logic        i_xfer_done,
    input  logic [2:0]  i_rd_idx,
    output logic [31:0] o_rd_data,
    output logic [3:0]  o_wait
);

    localparam int NUM_RW = int'(IDX_SCRATCH_HI) + 1;

    logic [31:0]       r_bank [NUM_RW];
    logic [NUM_RW-1:0] w_we;
    logic [31:0]       r_xfer_cnt;

    generate
        for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_we
            assign w_we[gi] = i_wr_en && (i_wr_idx == 3'(gi));
        end
    endgenerate

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_bank[i] <= (i == 0) ? {28'd0, RESET_WAIT} : 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_we[i]) begin
                    r_bank[i] <= i_wr_data;
                end
            end
        end
    end

    // Wraps naturally at 32 bits.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_xfer_cnt <= 32'd0;
        end else if (i_xfer_done) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    always_comb begin
        o_rd_data = 32'd0;
        case (i_rd_idx) inside
            IDX_CTRL:                         o_rd_data = r_bank[IDX_CTRL];
            [IDX_SCRATCH_LO:IDX_SCRATCH_HI]:  o_rd_data = r_bank[i_rd_idx];
            IDX_XFER_CNT:                     o_rd_data = r_xfer_cnt;
            IDX_ID:                           o_rd_data = ID_VALUE;
            default:                          o_rd_data = 32'd0;
        endcase
    end

    assign o_wait = r_bank[IDX_CTRL][3:0];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states: FSM, address capture and
// error decode; storage lives in apb_slave_regs.
`timescale 1ns/1ps
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE   = 32'hA2B0_0001,
    parameter logic [3:0]  RESET_WAIT = 4'd0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    state_t      r_state, w_state_next;
    logic [3:0]  r_wcnt, w_wcnt_next;
    logic [31:0] r_addr, r_wdata;
    logic        r_write;
    logic        r_pready, r_pslverr;
    logic [31:0] r_prdata;

    logic        w_setup, w_commit;
    logic [31:0] w_cur_addr;
    logic        w_cur_write, w_cur_err;
    logic [31:0] w_rd_data;
    logic [3:0]  w_wait;

    assign w_setup     = (r_state == ST_IDLE) && psel && !penable;
    // In IDLE the transfer being captured is still on the bus.
    assign w_cur_addr  = (r_state == ST_IDLE) ? paddr  : r_addr;
    assign w_cur_write = (r_state == ST_IDLE) ? pwrite : r_write;
    assign w_cur_err   = (w_cur_addr[1:0] != 2'b00)
                      || (w_cur_addr[31:5] != BASE_ADDR[31:5])
                      || (w_cur_write && is_ro_idx(w_cur_addr[4:2]));
    assign w_commit    = (r_state == ST_RESP) && psel && !r_pslverr;

    apb_slave_regs #(
        .ID_VALUE   (ID_VALUE),
        .RESET_WAIT (RESET_WAIT)
    ) u_regs (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .i_wr_en     (w_commit && r_write),
        .i_wr_idx    (r_addr[4:2]),
        .i_wr_data   (r_wdata),
        .i_xfer_done (w_commit),
        .i_rd_idx    (w_cur_addr[4:2]),
        .o_rd_data   (w_rd_data),
        .o_wait      (w_wait)
    );

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    if (w_wait == 4'd0) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_wcnt_next  = w_wait - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    w_state_next = ST_IDLE;
                    w_wcnt_next  = 4'd0;
                end else if (r_wcnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_wcnt_next  = r_wcnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_wcnt_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_addr    <= 32'd0;
            r_write   <= 1'b0;
            r_wdata   <= 32'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= 32'd0;
        end else begin
            if (w_setup) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
            end
            r_pready  <= (w_state_next == ST_RESP);
            r_pslverr <= (w_state_next == ST_RESP) && w_cur_err;
            r_prdata  <= ((w_state_next == ST_RESP) && !w_cur_err && !w_cur_write)
                         ? w_rd_data : 32'd0;
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed table, corner-case
// sequences and randomized transfers against a register-map reference model.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

    localparam logic [31:0] ID_VAL  = 32'hA2B0_0001;
    localparam logic [3:0]  RST_W   = 4'd0;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_slave_regfile #(
        .BASE_ADDR  (32'h0000_0000),
        .ID_VALUE   (ID_VAL),
        .RESET_WAIT (RST_W)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 hclk = ~hclk;

    // Reference model: register contents by index, transfer counter.
    logic [31:0] m_reg [0:5];
    logic [31:0] m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 32'd0;
        m_reg[0] = {28'd0, RST_W};
        m_cnt    = 32'd0;
    endfunction

    function automatic void model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic er, output int w);
        int idx;
        idx = int'(a[4:2]);
        w   = int'(m_reg[0][3:0]);
        er  = (a[1:0] != 2'b00) || (a[31:5] != 27'd0) || (wr && idx >= 6);
        rd  = 32'd0;
        if (!er && !wr) rd = (idx < 6) ? m_reg[idx] : (idx == 6) ? m_cnt : ID_VAL;
        if (!er) begin
            if (wr) m_reg[idx] = d;
            m_cnt = m_cnt + 32'd1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int w,
                            output logic idle_bad, output logic tmo);
        @(negedge hclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge hclk);
        penable  = 1'b1;
        w        = 0;
        idle_bad = 1'b0;
        tmo      = 1'b0;
        while (!pready && !tmo) begin
            if (prdata != 32'd0 || pslverr) idle_bad = 1'b1;
            w++;
            if (w > 40) tmo = 1'b1;
            else @(negedge hclk);
        end
        rd = prdata;
        er = pslverr;
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0;
        if (pready || prdata != 32'd0 || pslverr) idle_bad = 1'b1;
    endtask

    task automatic run_and_check(input string name, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d);
        logic [31:0] erd, ard;
        logic        eer, aer, ib, tmo;
        int          ew, aw;
        model_xfer(wr, a, d, erd, eer, ew);
        apb_xfer(wr, a, d, ard, aer, aw, ib, tmo);
        $display("xfer %-12s %s addr=%08h wdata=%08h rdata=%08h err=%0d waits=%0d",
                 name, wr ? "W" : "R", a, d, ard, aer, aw);
        chk({name, ".timeout"}, 32'(tmo), 32'd0);
        chk({name, ".rdata"}, ard, erd);
        chk({name, ".pslverr"}, 32'(aer), 32'(eer));
        chk({name, ".waits"}, 32'(aw), 32'(ew));
        chk({name, ".idle_zero"}, 32'(ib), 32'd0);
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] ard, drd;
        logic        aer, ib, tmo, dreg;
        int          aw, dw;
        logic        saw_pready;

        vecs[0]  = '{1'b1, 32'h08, 32'h1234_5678, 32'h0,         1'b0, 0};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,         32'h1234_5678, 1'b0, 0};
        vecs[2]  = '{1'b1, 32'h00, 32'h3,         32'h0,         1'b0, 0};
        vecs[3]  = '{1'b0, 32'h1C, 32'h0,         ID_VAL,        1'b0, 3};
        vecs[4]  = '{1'b1, 32'h18, 32'hDEAD_BEEF, 32'h0,         1'b1, 3};
        vecs[5]  = '{1'b0, 32'h02, 32'h0,         32'h0,         1'b1, 3};
        vecs[6]  = '{1'b1, 32'h40, 32'h5555_5555, 32'h0,         1'b1, 3};
        vecs[7]  = '{1'b0, 32'h18, 32'h0,         32'h4,         1'b0, 3};
        vecs[8]  = '{1'b1, 32'h00, 32'h0,         32'h0,         1'b0, 3};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,         32'h0,         1'b0, 0};
        vecs[10] = '{1'b0, 32'h18, 32'h0,         32'h7,         1'b0, 0};
        vecs[11] = '{1'b0, 32'h08, 32'h0,         32'h1234_5678, 1'b0, 0};
        vecs[12] = '{1'b1, 32'h1C, 32'h1,         32'h0,         1'b1, 0};

        // Reset state
        model_reset();
        repeat (3) @(negedge hclk);
        chk("reset.pready", 32'(pready), 32'd0);
        chk("reset.pslverr", 32'(pslverr), 32'd0);
        chk("reset.prdata", prdata, 32'd0);
        hresetn = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            model_xfer(vecs[i].write, vecs[i].addr, vecs[i].wdata, drd, dreg, dw);
            apb_xfer(vecs[i].write, vecs[i].addr, vecs[i].wdata, ard, aer, aw, ib, tmo);
            $display("xfer vec%0d        %s addr=%08h wdata=%08h rdata=%08h err=%0d waits=%0d",
                     i, vecs[i].write ? "W" : "R", vecs[i].addr, vecs[i].wdata, ard, aer, aw);
            chk($sformatf("vec%0d.timeout", i), 32'(tmo), 32'd0);
            chk($sformatf("vec%0d.rdata", i), ard, vecs[i].exp_rdata);
            chk($sformatf("vec%0d.pslverr", i), 32'(aer), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.waits", i), 32'(aw), 32'(vecs[i].exp_waits));
            chk($sformatf("vec%0d.idle_zero", i), 32'(ib), 32'd0);
        end

        // Counter wrap via backdoor preload
        @(negedge hclk);
        force dut.u_regs.r_xfer_cnt = 32'hFFFF_FFFF;
        @(negedge hclk);
        release dut.u_regs.r_xfer_cnt;
        m_cnt = 32'hFFFF_FFFF;
        run_and_check("wrap_read", 1'b0, 32'h08, 32'h0);
        run_and_check("wrap_cnt0", 1'b0, 32'h18, 32'h0);
        run_and_check("wrap_cnt1", 1'b0, 32'h18, 32'h0);

        // Abort during WAIT with W=2
        run_and_check("abort_ctrl", 1'b1, 32'h00, 32'h2);
        run_and_check("abort_pre", 1'b1, 32'h10, 32'h1111_1111);
        @(negedge hclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h2222_2222;
        @(negedge hclk);
        penable = 1'b1;
        saw_pready = pready;
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            saw_pready = saw_pready | pready;
            @(negedge hclk);
        end
        $display("xfer abort_wait   W addr=00000010 wdata=22222222 pready_seen=%0d", saw_pready);
        chk("abort.no_pready", 32'(saw_pready), 32'd0);
        run_and_check("abort_rd", 1'b0, 32'h10, 32'h0);
        run_and_check("abort_cnt", 1'b0, 32'h18, 32'h0);
        run_and_check("abort_wr2", 1'b1, 32'h10, 32'h3333_3333);
        run_and_check("abort_rd2", 1'b0, 32'h10, 32'h0);

        // Reset during WAIT with W=5
        run_and_check("rst_ctrl", 1'b1, 32'h00, 32'h5);
        @(negedge hclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        $display("xfer rst_in_wait  W addr=0000000c pready=%0d pslverr=%0d prdata=%08h",
                 pready, pslverr, prdata);
        chk("rst.pready", 32'(pready), 32'd0);
        chk("rst.pslverr", 32'(pslverr), 32'd0);
        chk("rst.prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
        run_and_check("rst_rd0c", 1'b0, 32'h0C, 32'h0);
        run_and_check("rst_ctrl_rd", 1'b0, 32'h00, 32'h0);
        run_and_check("rst_cnt", 1'b0, 32'h18, 32'h0);

        // Randomized transfers
        for (int t = 0; t < 200; t++) begin
            logic [2:0]  idx;
            logic [31:0] a, d;
            logic        wr;
            int          r;
            idx = 3'($urandom_range(0, 7));
            a   = {27'd0, idx, 2'b00};
            r   = int'($urandom_range(0, 15));
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) a[31:5] = 27'($urandom_range(1, 32'h07FF_FFFF));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (idx == 3'd0) d[3:0] = 4'($urandom_range(0, 4));
            run_and_check($sformatf("rnd%0d", t), wr, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
